// File: rtl/spad_emu.sv
// spad_emu: register-programmed multi-channel SPAD photon event emulator
module spad_emu #(
    parameter int CH = 4,
    parameter int EVT = 3,
    parameter int DW = 16,
    parameter int IW = 16,
    parameter int RANGE = 512,
    parameter int PULSE_W = 3,
    parameter int GATE_W = 1,
    localparam int CW = (CH > 1) ? $clog2(CH) : 1,
    localparam int EW = (EVT > 1) ? $clog2(EVT) : 1,
    localparam int KW = $clog2(EVT + 1),
    localparam int PW = $clog2(PULSE_W + 1),
    localparam int GW = $clog2(GATE_W + 1)
) (
    input  logic             clk_250M,
    input  logic             rst_auto,
    input  logic             TDC_start,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [EW-1:0]    cfg_evt,
    input  logic [DW-1:0]    cfg_delay,
    input  logic [IW-1:0]    cfg_int,
    output logic             cfg_err,
    output logic             busy,
    output logic [CH-1:0]    photon,
    output logic [CH-1:0]    trig,
    output logic [CH-1:0]    time_gate,
    output logic [CH*IW-1:0] spad_int,
    output logic [CH*KW-1:0] evt_cnt
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 r_state;
    logic [DW-1:0]          r_cnt;
    logic                   r_start_d;
    logic                   r_cfg_err;
    logic [DW-1:0]          r_dly [CH][EVT];
    logic [IW-1:0]          r_int [CH][EVT];
    logic [KW-1:0]          r_k [CH];
    logic [PW-1:0]          r_pc [CH];
    logic [GW-1:0]          r_gc [CH];
    logic [CH-1:0]          r_trig;
    logic [CH-1:0][IW-1:0]  r_spint;
    logic [CH-1:0][KW-1:0]  r_ec;

    logic                   w_run;
    logic                   w_start;
    logic                   w_bad;
    logic [CH-1:0]          w_live;
    logic [CH-1:0]          w_fire;
    logic [CH-1:0]          w_skip;
    logic [DW-1:0]          w_dly [CH];
    logic [IW-1:0]          w_int [CH];

    assign w_run    = (r_state == S_RUN);
    assign w_start  = TDC_start && !r_start_d;
    assign w_bad    = (int'(cfg_ch) >= CH) || (int'(cfg_evt) >= EVT);
    assign busy     = w_run;
    assign cfg_err  = r_cfg_err;
    assign trig     = r_trig;
    assign spad_int = r_spint;
    assign evt_cnt  = r_ec;

    // per-channel slot lookup: fire when the current slot's delay has been reached, skip disabled slots
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_live[c]    = int'(r_k[c]) < EVT;
            w_dly[c]     = w_live[c] ? r_dly[c][r_k[c][EW-1:0]] : '1;
            w_int[c]     = r_int[c][r_k[c][EW-1:0]];
            w_fire[c]    = w_run && w_live[c] && (w_dly[c] != '1) && (r_cnt >= w_dly[c]);
            w_skip[c]    = w_run && w_live[c] && (w_dly[c] == '1);
            photon[c]    = (r_pc[c] != '0);
            time_gate[c] = (r_gc[c] != '0);
        end
    end

    // config store, IDLE/RUN window FSM, event pointers and retriggerable pulse counters
    always_ff @(posedge clk_250M) begin
        if (rst_auto) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_start_d <= 1'b0;
            r_cfg_err <= 1'b0;
            r_trig    <= '0;
            r_spint   <= '0;
            r_ec      <= '0;
            for (int c = 0; c < CH; c++) begin
                r_k[c]  <= '0;
                r_pc[c] <= '0;
                r_gc[c] <= '0;
                for (int e = 0; e < EVT; e++) begin
                    r_dly[c][e] <= '1;
                    r_int[c][e] <= '0;
                end
            end
        end else begin
            r_start_d <= TDC_start;
            r_cfg_err <= cfg_we && (w_run || w_bad);
            if (cfg_we && !w_run && !w_bad) begin
                r_dly[cfg_ch][cfg_evt] <= cfg_delay;
                r_int[cfg_ch][cfg_evt] <= cfg_int;
            end
            for (int c = 0; c < CH; c++) begin
                r_pc[c] <= w_fire[c] ? PW'(PULSE_W) : ((r_pc[c] != '0) ? r_pc[c] - PW'(1) : r_pc[c]);
                r_gc[c] <= w_fire[c] ? GW'(GATE_W) : ((r_gc[c] != '0) ? r_gc[c] - GW'(1) : r_gc[c]);
            end
            if (!w_run) begin
                if (w_start) begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                    r_trig  <= '0;
                    r_spint <= '0;
                    r_ec    <= '0;
                    for (int c = 0; c < CH; c++) r_k[c] <= '0;
                end
            end else begin
                r_cnt <= r_cnt + DW'(1);
                if (r_cnt == DW'(RANGE - 1)) r_state <= S_IDLE;
                for (int c = 0; c < CH; c++) begin
                    if (w_fire[c]) begin
                        r_k[c]     <= r_k[c] + KW'(1);
                        r_trig[c]  <= 1'b1;
                        r_spint[c] <= w_int[c];
                        r_ec[c]    <= r_ec[c] + KW'(1);
                    end else if (w_skip[c]) begin
                        r_k[c] <= r_k[c] + KW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spad_emu.sv
// tb_spad_emu: directed and randomized checks of spad_emu against an event-list reference model
module tb_spad_emu;
    localparam int CH = 4, EVT = 3, DW = 16, IW = 16, RANGE = 512, PULSE_W = 3, GATE_W = 1, KW = 2;

    logic clk = 0, rst = 1, tdc = 0, we = 0;
    logic [1:0] wch = 0, wevt = 0;
    logic [DW-1:0] wdly = 0;
    logic [IW-1:0] wint = 0;
    logic cfg_err, busy;
    logic [CH-1:0] photon, trig, time_gate;
    logic [CH*IW-1:0] spad_int;
    logic [CH*KW-1:0] evt_cnt;

    spad_emu dut (
        .clk_250M(clk), .rst_auto(rst), .TDC_start(tdc), .cfg_we(we), .cfg_ch(wch), .cfg_evt(wevt),
        .cfg_delay(wdly), .cfg_int(wint), .cfg_err(cfg_err), .busy(busy), .photon(photon),
        .trig(trig), .time_gate(time_gate), .spad_int(spad_int), .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int now = 0, e0 = 0, err_at = -1;
    bit win = 0, prev = 0, busy_b, st;
    int mdly [CH][EVT];
    logic [IW-1:0] mint [CH][EVT];
    int fq_f [CH][$];
    logic [IW-1:0] fq_i [CH][$];
    int t, f, d, fx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, now, act, exp_v);
        end
    endtask

    // reference model: tracks config, window start edge and absolute fire edges from each window
    always @(posedge clk) begin
        busy_b = win && (now >= e0) && (now < e0 + RANGE);
        now++;
        if (rst) begin
            win = 0; prev = 0; err_at = -1;
            for (int c = 0; c < CH; c++) begin
                fq_f[c].delete(); fq_i[c].delete();
                for (int e = 0; e < EVT; e++) begin mdly[c][e] = 65535; mint[c][e] = 0; end
            end
        end else begin
            st = tdc && !prev;
            prev = tdc;
            if (we) begin
                if (busy_b || int'(wevt) >= EVT) err_at = now;
                else begin mdly[wch][wevt] = wdly; mint[wch][wevt] = wint; end
            end
            if (st && !busy_b) begin
                win = 1; e0 = now;
                for (int c = 0; c < CH; c++) begin
                    t = 0;
                    for (int k = 0; k < EVT; k++) begin
                        d = mdly[c][k];
                        if (d == 65535) begin t++; continue; end
                        if (d >= RANGE) break;
                        f = (t > d) ? t : d;
                        if (f > RANGE - 1) break;
                        fq_f[c].push_back(e0 + f + 1);
                        fq_i[c].push_back(mint[c][k]);
                        t = f + 1;
                    end
                end
            end
        end
    end

    logic [CH-1:0] eph, etr, etg;
    logic [CH-1:0][IW-1:0] esi;
    logic [CH-1:0][KW-1:0] eec;

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (now > 0) begin
            for (int c = 0; c < CH; c++) begin
                eph[c] = 0; etr[c] = 0; etg[c] = 0; esi[c] = '0; eec[c] = '0;
                for (int i = 0; i < fq_f[c].size(); i++) begin
                    fx = fq_f[c][i];
                    if (fx <= now && now - fx < PULSE_W) eph[c] = 1;
                    if (fx <= now && now - fx < GATE_W) etg[c] = 1;
                    if (win && fx > e0 && fx <= now) begin
                        etr[c] = 1; esi[c] = fq_i[c][i]; eec[c] = eec[c] + 1'b1;
                    end
                end
            end
            chk("busy", busy, win && now >= e0 && now < e0 + RANGE);
            chk("cfg_err", cfg_err, err_at == now);
            chk("photon", photon, eph);
            chk("time_gate", time_gate, etg);
            chk("trig", trig, etr);
            chk("spad_int", spad_int, esi);
            chk("evt_cnt", evt_cnt, eec);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_edge(input int n);
        while (now < n) step();
        @(negedge clk);
    endtask

    task automatic wr(input int c, input int e, input int dl, input int iv);
        we = 1; wch = 2'(c); wevt = 2'(e); wdly = DW'(dl); wint = IW'(iv);
        step();
        we = 0;
    endtask

    int be0, be1, be2, be3;

    initial begin
        repeat (3) step();
        rst = 0;
        @(negedge clk);
        chk("lit reset busy", busy, 0);
        chk("lit reset outs", {photon, trig, time_gate, evt_cnt}, 0);
        wr(0, 0, 10, 5); wr(0, 1, 20, 6); wr(0, 2, 30, 7);
        wr(1, 0, 10, 1); wr(1, 1, 11, 2); wr(1, 2, 12, 3);
        wr(2, 0, 40, 8); wr(2, 1, 20, 9); wr(2, 2, 600, 10);
        wr(0, 3, 5, 99);
        @(negedge clk);
        chk("lit oor cfg_err", cfg_err, 1);
        step(); @(negedge clk);
        chk("lit cfg_err one pulse", cfg_err, 0);
        tdc = 1; step(); be0 = now; repeat (2) step(); tdc = 0;
        at_edge(be0 + 10); chk("lit ph0 before", photon[0], 0);
        at_edge(be0 + 11); chk("lit ph0 rise", photon[0], 1); chk("lit si0 5", spad_int[15:0], 5);
        at_edge(be0 + 13); chk("lit ph0 width", photon[0], 1);
        at_edge(be0 + 14); chk("lit ph0 fall", photon[0], 0);
        at_edge(be0 + 15); chk("lit ph1 merged", photon[1], 1);
        at_edge(be0 + 16); chk("lit ph1 fall", photon[1], 0);
        at_edge(be0 + 42); chk("lit ph2 second", photon[2], 1);
        at_edge(be0 + 100);
        chk("lit ec0 3", evt_cnt[1:0], 3); chk("lit ec2 2", evt_cnt[5:4], 2);
        chk("lit si0 7", spad_int[15:0], 7);
        we = 1; wch = 0; wevt = 0; wdly = 0; wint = 16'h55; tdc = 1;
        step(); we = 0; tdc = 0;
        @(negedge clk); chk("lit busy cfg_err", cfg_err, 1);
        at_edge(be0 + 511); chk("lit busy held", busy, 1);
        at_edge(be0 + 512); chk("lit busy fall", busy, 0); chk("lit trig hold", trig[0], 1);
        chk("lit si hold", spad_int[15:0], 7);
        tdc = 1; step(); be1 = now; tdc = 0;
        @(negedge clk);
        chk("lit 2nd start busy", busy, 1); chk("lit 2nd trig clr", trig, 0);
        chk("lit 2nd si clr", spad_int, 0);
        at_edge(be1 + 1); chk("lit dropped write", photon[0], 0);
        at_edge(be1 + 11); chk("lit 2nd ph0", photon[0], 1);
        at_edge(be1 + 511); tdc = 1;
        step(); step(); tdc = 0;
        @(negedge clk); chk("lit late start ignored", busy, 0);
        step();
        tdc = 1; step(); be2 = now; tdc = 0;
        at_edge(be2 + 24); rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("lit rst busy", busy, 0); chk("lit rst trig", trig, 0); chk("lit rst si", spad_int, 0);
        tdc = 1; step(); be3 = now; tdc = 0;
        at_edge(be3 + 11); chk("lit cleared cfg ph0", photon[0], 0);
        at_edge(be3 + 45); chk("lit cleared cfg ec", evt_cnt, 0);
        for (int i = 0; i < 12000; i++) begin
            rst  = ($urandom_range(0, 2999) == 0);
            tdc  = ($urandom_range(0, 99) < 2);
            we   = ($urandom_range(0, 19) == 0);
            wch  = 2'($urandom_range(0, 3));
            wevt = 2'($urandom_range(0, 3));
            wdly = ($urandom_range(0, 9) == 0) ? 16'hffff : DW'($urandom_range(0, 560));
            wint = IW'($urandom);
            step();
        end
        rst = 0; we = 0; tdc = 0;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spad_emu.md
# spad_emu

Synthesizable, parametrised successor to the behavioural SPAD model. It emulates up to CH SPAD channels, each firing up to EVT photon events per TDC_start at register-programmed delays with a per-event intensity. The block sits in front of the TDC/histogram chain on FPGA and emulation builds, replacing file-driven stimulus. Delays are counted in clk_250M cycles over a fixed range window.

## Interface
Parameters:
- CH, 4: number of emulated channels.
- EVT, 3: event slots per channel.
- DW, 16: delay field width, in clock cycles.
- IW, 16: intensity width.
- RANGE, 512: window length in cycles (2048 ns at 250 MHz). Must satisfy RANGE ≤ 2^DW − 1.
- PULSE_W, 3: photon pulse width in cycles (≥1).
- GATE_W, 1: time_gate pulse width in cycles (≥1).

Ports:
- clk_250M  in  1  sole clock, all logic on its rising edge.
- rst_auto  in  1  reset, synchronous, active-high.
- TDC_start  in  1  start request; its rising edge is detected internally by the block.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  clog2(CH)  channel index for the write.
- cfg_evt  in  clog2(EVT)  slot index for the write.
- cfg_delay  in  DW  event delay; all-ones disables the slot.
- cfg_int  in  IW  event intensity.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- busy  out  1  high while in RUN.
- photon  out  CH  per-channel photon pulse.
- trig  out  CH  sticky per-channel hit flag.
- time_gate  out  CH  short pulse per event.
- spad_int  out  CH*IW  last intensity per channel; channel c occupies bits [c*IW +: IW].
- evt_cnt  out  CH*clog2(EVT+1)  number of events fired in the current or last window.

## Operation
- Config store holds CH×EVT entries of {delay, int}.
  - Reset sets every delay to all-ones (disabled) and every int to 0.
  - A write is accepted only when busy=0. A write while busy=1 is dropped and cfg_err pulses for one cycle.
  - An out-of-range cfg_ch or cfg_evt is dropped and cfg_err pulses.
- The FSM has two states, IDLE and RUN.
  - IDLE → RUN on a detected start edge: TDC_start=1 sampled with the previous sample 0.
  - On entry to RUN: cnt is cleared to 0, every channel pointer k goes to 0, and trig, spad_int and evt_cnt are cleared.
  - In RUN, cnt increments each cycle.
  - RUN → IDLE on the edge following the cycle where cnt == RANGE−1.
  - A start edge seen while in RUN is ignored; it does not restart the window.
- Per channel, while in RUN:
  - When k < EVT, delay[k] is not all-ones, and cnt ≥ delay[k], the channel fires. It then increments k.
  - A disabled slot is skipped, and k advances with no output.
  - A channel fires at most once per cycle. A non-monotonic delay therefore fires on the cycle after the previous event.
- On a fire:
  - photon is set and its counter loads PULSE_W. A fire while photon is already high reloads the counter, extending the pulse.
  - trig is set to 1.
  - spad_int is loaded with int[k].
  - time_gate is set for GATE_W cycles, retriggerable in the same way.
  - evt_cnt is incremented.
- Events with delay ≥ RANGE never fire.
- In-flight photon and time_gate pulses complete normally after RUN → IDLE.
- trig, spad_int and evt_cnt hold their values in IDLE until the next start edge or reset.

## Timing
- Reset values: photon, trig, time_gate, spad_int, evt_cnt, busy and cfg_err are all 0. The FSM is in IDLE with cnt=0 and the start-edge history register at 0.
- Let E0 be the edge that samples the start edge.
  - busy=1 from E0.
  - cnt=0 during the cycle after E0.
- An event with delay d produces registered photon, trig, time_gate and spad_int changes at edge E0+d+1. photon stays high for PULSE_W cycles.
- busy falls at edge E0+RANGE.
- A start edge sampled in the same cycle busy falls is ignored. A start edge one cycle later is accepted.
- cfg_err is asserted at the edge after the rejected cfg_we.
- A write in IDLE takes effect for any start edge detected at the next edge or later.
- rst_auto mid-RUN: at the next edge all outputs return to reset values and the config store is cleared.
- rst_auto has priority over a simultaneous start edge and a simultaneous cfg_we.
- A start edge and a cfg_we in the same IDLE cycle: the write is accepted and is visible to the window just started.

## Test plan
- Program ch0 delays 10/20/30 with ints 5/6/7, then pulse TDC_start. Expect photon[0] rising at E0+11, E0+21 and E0+31, each 3 cycles wide. spad_int[0] steps 5→6→7, trig[0]=1, evt_cnt[0]=3, and busy falls at E0+512.
- Program ch1 delays 10/11/12 (overlapping pulses). Expect one merged photon[1] high from E0+11 through E0+15, time_gate[1] high on three consecutive cycles, and evt_cnt=3.
- Program ch2 delays 40/20/600 with slot 2 out of range. Expect fires at E0+41 and E0+42 and nothing for slot 2. evt_cnt=2.
- Issue cfg_we and a second TDC_start while busy. Expect cfg_err to pulse once, the config to be unchanged, and the window not to be restarted.
- Assert rst_auto at E0+25 mid-window. Expect all outputs 0 at the next edge. A subsequent start with no reprogramming produces no photons.
- Run two back-to-back windows. Expect trig and spad_int to hold after the first window and clear at the second E0.
